// File: rtl/grad_dir_hist_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// grad_dir_hist_if : sample, direction-ROM and histogram-dump bundle. Rev 1.0
// ---------------------------------------------------------------------------
interface grad_dir_hist_if #(
  parameter int GRAD_W = 9,
  parameter int MAG_W  = 10,
  parameter int ACC_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [GRAD_W-1:0] in_gx;
  logic [GRAD_W-1:0] in_gy;
  logic [MAG_W-1:0]  in_mag;
  logic              in_last;
  logic [7:0]        rom_a;
  logic [4:0]        rom_spo;
  logic              hist_valid;
  logic              hist_ready;
  logic [4:0]        hist_bin;
  logic [ACC_W-1:0]  hist_data;
  logic              hist_last;
  logic              busy;

  modport slave (
    input  in_valid, in_gx, in_gy, in_mag, in_last, rom_spo, hist_ready,
    output in_ready, rom_a, hist_valid, hist_bin, hist_data, hist_last, busy
  );

  modport master (
    output in_valid, in_gx, in_gy, in_mag, in_last, rom_spo, hist_ready,
    input  in_ready, rom_a, hist_valid, hist_bin, hist_data, hist_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/grad_dir_hist.sv
`default_nettype none
// ---------------------------------------------------------------------------
// grad_dir_hist : gradient -> direction-ROM lookup -> 32-bin magnitude
//                 histogram, dumped over valid/ready per window. Rev 1.0
// ---------------------------------------------------------------------------
module grad_dir_hist #(
  parameter int GRAD_W = 9,
  parameter int MAG_W  = 10,
  parameter int ACC_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  grad_dir_hist_if.slave bus
);
  localparam int c_AW = GRAD_W - 1;
  localparam int c_SW = $clog2(GRAD_W);
  localparam logic [ACC_W-1:0] c_ACC_MAX = '1;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DUMP  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic              w_accept, w_beat, w_pipe_busy;
  logic [c_AW-1:0]   w_ax, w_ay, w_or;
  logic [c_SW-1:0]   w_shift;
  logic [3:0]        w_ax4, w_ay4;
  logic [4:0]        w_bin;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_sat;

  logic              r_s1_valid, r_s1_zero;
  logic [7:0]        r_rom_a;
  logic [1:0]        r_s1_q;
  logic [MAG_W-1:0]  r_s1_mag;
  logic              r_s2_valid, r_s2_zero;
  logic [4:0]        r_s2_bin;
  logic [MAG_W-1:0]  r_s2_mag;
  logic              r_s3_valid, r_s3_zero;
  logic [4:0]        r_s3_bin;
  logic [MAG_W-1:0]  r_s3_mag;
  logic [4:0]        r_cnt;
  logic [ACC_W-1:0]  r_hist [32];

  function automatic logic [c_AW-1:0] f_abs(input logic signed [GRAD_W-1:0] v);
    logic signed [GRAD_W-1:0] n;
    if (!v[GRAD_W-1]) return v[c_AW-1:0];
    n = -v;
    if (n[GRAD_W-1]) return '1;  // most-negative input has no positive twin
    return n[c_AW-1:0];
  endfunction

  assign w_accept    = bus.in_valid && (r_state == ST_ACCUM);
  assign w_beat      = (r_state == ST_DUMP) && bus.hist_ready;
  assign w_pipe_busy = r_s1_valid || r_s2_valid || r_s3_valid;

  assign w_ax = f_abs(bus.in_gx);
  assign w_ay = f_abs(bus.in_gy);
  assign w_or = w_ax | w_ay;

  // Shift so the larger component's MSB lands on bit 3.
  always_comb begin
    w_shift = '0;
    for (int i = 4; i < c_AW; i++) begin
      if (w_or[i]) w_shift = c_SW'(i - 3);
    end
  end

  assign w_ax4 = 4'(w_ax >> w_shift);
  assign w_ay4 = 4'(w_ay >> w_shift);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_rom_a    <= '0;
      r_s1_q     <= '0;
      r_s1_mag   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_rom_a   <= {w_ay4, w_ax4};
        r_s1_q    <= {bus.in_gy[GRAD_W-1], bus.in_gy[GRAD_W-1] ^ bus.in_gx[GRAD_W-1]};
        r_s1_mag  <= bus.in_mag;
        r_s1_zero <= (w_or == '0);
      end
    end
  end

  always_comb begin
    w_bin = '0;
    unique case (r_s1_q)
      2'd0:    w_bin = bus.rom_spo;
      2'd1:    w_bin = 5'd16 - bus.rom_spo;
      2'd2:    w_bin = 5'd16 + bus.rom_spo;
      default: w_bin = 5'd0 - bus.rom_spo;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_bin   <= '0;
      r_s2_mag   <= '0;
      r_s3_valid <= 1'b0;
      r_s3_zero  <= 1'b0;
      r_s3_bin   <= '0;
      r_s3_mag   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
      if (r_s1_valid) begin
        r_s2_zero <= r_s1_zero;
        r_s2_bin  <= w_bin;
        r_s2_mag  <= r_s1_mag;
      end
      if (r_s2_valid) begin
        r_s3_zero <= r_s2_zero;
        r_s3_bin  <= r_s2_bin;
        r_s3_mag  <= r_s2_mag;
      end
    end
  end

  // Read-modify-write at the final stage keeps back-to-back hits on one bin exact.
  assign w_sum = {1'b0, r_hist[r_s3_bin]} + {{(ACC_W + 1 - MAG_W){1'b0}}, r_s3_mag};
  assign w_sat = w_sum[ACC_W] ? c_ACC_MAX : w_sum[ACC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_hist[i] <= '0;
    end else begin
      if (r_s3_valid && !r_s3_zero) r_hist[r_s3_bin] <= w_sat;
      if (w_beat) r_hist[r_cnt] <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_DRAIN) r_cnt <= '0;
      else if (w_beat)         r_cnt <= r_cnt + 5'd1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.in_ready   = 1'b0;
    bus.hist_valid = 1'b0;
    bus.hist_last  = 1'b0;
    bus.hist_data  = '0;
    unique case (r_state)
      ST_ACCUM: begin
        bus.in_ready = 1'b1;
        if (w_accept && bus.in_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!w_pipe_busy) w_state_nxt = ST_DUMP;
      end
      ST_DUMP: begin
        bus.hist_valid = 1'b1;
        bus.hist_last  = (r_cnt == 5'd31);
        bus.hist_data  = r_hist[r_cnt];
        if (w_beat && (r_cnt == 5'd31)) w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  assign bus.rom_a    = r_rom_a;
  assign bus.hist_bin = r_cnt;
  assign bus.busy     = (r_state != ST_ACCUM) || w_pipe_busy;

endmodule
`default_nettype wire

// File: tb/tb_grad_dir_hist.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_grad_dir_hist : randomized scoreboard bench for grad_dir_hist. Rev 1.0
// ---------------------------------------------------------------------------
module tb_grad_dir_hist;
  localparam int GRAD_W  = 9;
  localparam int MAG_W   = 10;
  localparam int ACC_W   = 16;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
  localparam int ABS_MAX = (1 << (GRAD_W - 1)) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  grad_dir_hist_if #(.GRAD_W(GRAD_W), .MAG_W(MAG_W), .ACC_W(ACC_W)) bus ();

  grad_dir_hist #(.GRAD_W(GRAD_W), .MAG_W(MAG_W), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [4:0] rom [256];
  assign bus.rom_spo = rom[bus.rom_a];

  typedef struct {
    int bin;
    int data;
    bit last;
  } beat_t;

  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    model[32];
  int    ready_pct = 100;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_abs(int v);
    int a = (v < 0) ? -v : v;
    return (a > ABS_MAX) ? ABS_MAX : a;
  endfunction

  function automatic int m_addr(int gx, int gy);
    int ax = m_abs(gx);
    int ay = m_abs(gy);
    int s  = 0;
    while ((ax >> s) > 15 || (ay >> s) > 15) s++;
    return (ay >> s) * 16 + (ax >> s);
  endfunction

  function automatic int m_bin(int gx, int gy);
    int spo = int'(rom[m_addr(gx, gy)]);
    int b;
    if (gx >= 0 && gy >= 0) b = spo;
    else if (gx < 0 && gy >= 0) b = 16 - spo;
    else if (gx < 0) b = 16 + spo;
    else b = 32 - spo;
    return ((b % 32) + 32) % 32;
  endfunction

  task automatic push_window();
    beat_t e;
    for (int i = 0; i < 32; i++) begin
      e.bin  = i;
      e.data = model[i];
      e.last = (i == 31);
      sb.push_back(e);
      model[i] = 0;
    end
  endtask

  // Called on a negedge; returns on the negedge after the sample is taken.
  task automatic send(int gx, int gy, int mag, bit last);
    int guard = 0;
    int b;
    bus.in_valid = 1'b1;
    bus.in_gx    = GRAD_W'(gx);
    bus.in_gy    = GRAD_W'(gy);
    bus.in_mag   = MAG_W'(mag);
    bus.in_last  = last;
    while (!bus.in_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        $display("FAIL accept_timeout: in_ready stuck low");
        $fatal(1, "bench aborted");
      end
    end
    @(negedge clk);
    check("rom_a", bus.rom_a, m_addr(gx, gy));
    if (!(gx == 0 && gy == 0)) begin
      b = m_bin(gx, gy);
      model[b] = (model[b] + mag > ACC_MAX) ? ACC_MAX : model[b] + mag;
    end
    if (last) push_window();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (sb.size() != 0 || bus.busy) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        $display("FAIL idle_timeout: %0d beats outstanding", sb.size());
        $fatal(1, "bench aborted");
      end
    end
  endtask

  task automatic rand_window(int n);
    int gx, gy;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        gx = 0;
        gy = 0;
      end else begin
        gx = int'($urandom_range(0, 511)) - 256;
        gy = int'($urandom_range(0, 511)) - 256;
      end
      send(gx, gy, int'($urandom_range(0, 1023)), i == n - 1);
    end
  endtask

  initial begin
    bus.hist_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2 bus.hist_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
  initial begin
    bit    stall = 1'b0;
    beat_t held;
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", bus.hist_valid, 1);
          check("hold_bin", bus.hist_bin, held.bin);
          check("hold_data", bus.hist_data, held.data);
          check("hold_last", bus.hist_last, held.last);
        end
        stall = 1'b0;
        if (bus.hist_valid) begin
          check("in_ready_dump", bus.in_ready, 0);
          if (bus.hist_ready) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: bin %0d data %0d, none expected", bus.hist_bin, bus.hist_data);
            end else begin
              e = sb.pop_front();
              check("beat_bin", bus.hist_bin, e.bin);
              check("beat_data", bus.hist_data, e.data);
              check("beat_last", bus.hist_last, e.last);
            end
          end else begin
            stall     = 1'b1;
            held.bin  = int'(bus.hist_bin);
            held.data = int'(bus.hist_data);
            held.last = bus.hist_last;
          end
        end
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 256; i++) rom[i] = 5'($urandom);
    rom[8'h05] = 5'd3;
    rom[8'h55] = 5'd2;
    rom[8'h6A] = 5'd3;
    for (int i = 0; i < 32; i++) model[i] = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_gx    = '0;
    bus.in_gy    = '0;
    bus.in_mag   = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rom_a", bus.rom_a, 0);
    check("rst_hist_valid", bus.hist_valid, 0);
    check("rst_hist_bin", bus.hist_bin, 0);
    check("rst_hist_data", bus.hist_data, 0);
    check("rst_hist_last", bus.hist_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    send(5, 0, 100, 1);     wait_idle();
    send(-5, 0, 7, 1);      wait_idle();
    send(5, -5, 7, 1);      wait_idle();
    send(40, 24, 9, 0);
    send(-256, 0, 11, 0);
    send(-40, -24, 13, 1);  wait_idle();
    for (int i = 0; i < 70; i++) send(5, 0, 1023, i == 69);
    wait_idle();
    send(0, 0, 500, 0);
    send(0, 0, 321, 1);     wait_idle();

    ready_pct = 50;
    for (int w = 0; w < 5; w++) begin
      rand_window(int'($urandom_range(1, 25)));
      wait_idle();
    end

    // Reset in the middle of a dump must discard everything.
    rand_window(8);
    guard = 0;
    while (!(bus.hist_valid && bus.hist_bin == 5'd10)) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        $display("FAIL dump_timeout: beat 10 never presented");
        $fatal(1, "bench aborted");
      end
    end
    #1 rst = 1'b1;
    sb.delete();
    for (int i = 0; i < 32; i++) model[i] = 0;
    @(negedge clk);
    check("midrst_hist_valid", bus.hist_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_busy", bus.busy, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    rand_window(6);
    wait_idle();
    send(0, 0, 99, 1);
    wait_idle();

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
